memory_responder: RTL and testbench

Target side of the core's memory interface: answers instruction fetches and data loads/stores issued by the core. It holds a word-addressed unified instruction/data RAM, preloaded through a valid/ready load port before the core is released. It checks every access for range and alignment, and halts the core on the first fault. It sits between the core and the testbench/loader in the top-level wrapper.

---
 rtl/memory_responder.sv | 126 ++++++++++++
 tb/tb_memory_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Unified instruction/data RAM that serves the core's fetch and load/store ports.
// It is preloaded through a valid/ready port, and any out-of-range or misaligned access halts the core.
module memory_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr,
  input  logic [31:0] data_addr,
  input  logic        should_read_mem,
  input  logic        should_write_mem,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        core_hold,
  output logic        fault,
  output logic [31:0] fault_addr
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  typedef enum logic [1:0] {StLoad, StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic [31:0] mem [Depth];

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [31:0]           mem_wdata;

  logic [31:0] instr_off, data_off, load_off;
  logic        active, load_fire, fetch_bad, data_bad, load_ok;

  // off is addr - BASE_ADDR. Because BASE_ADDR is word aligned, off[1:0] equals addr[1:0].
  function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] off);
    return (addr >= BASE_ADDR) && (off[31:ADDR_WIDTH+2] == '0) && (off[1:0] == 2'b00);
  endfunction

  always_comb begin
    instr_off = instr_addr - BASE_ADDR;
    data_off  = data_addr - BASE_ADDR;
    load_off  = load_addr - BASE_ADDR;

    active     = (state_q == StRun) && !reset;
    load_ready = (state_q == StLoad) && !reset;
    core_hold  = !active;
    load_fire  = load_ready && load_valid;

    fetch_bad = !addr_ok(instr_addr, instr_off);
    data_bad  = ((should_read_mem || should_write_mem) && !addr_ok(data_addr, data_off)) ||
                (should_read_mem && should_write_mem);
    load_ok   = addr_ok(load_addr, load_off);

    instr         = active ? mem[instr_off[ADDR_WIDTH+1:2]] : Nop;
    mem_read_data = (active && should_read_mem) ? mem[data_off[ADDR_WIDTH+1:2]] : '0;
  end

  always_comb begin
    state_d      = state_q;
    fault_d      = fault_q;
    fault_addr_d = fault_addr_q;
    mem_we       = 1'b0;
    mem_waddr    = data_off[ADDR_WIDTH+1:2];
    mem_wdata    = mem_write_data;

    unique case (state_q)
      StLoad: begin
        if (load_fire) begin
          if (!load_ok) begin
            state_d      = StHalt;
            fault_d      = 1'b1;
            fault_addr_d = load_addr;
          end else begin
            mem_we    = 1'b1;
            mem_waddr = load_off[ADDR_WIDTH+1:2];
            mem_wdata = load_data;
            if (load_last) state_d = StRun;
          end
        end
      end
      StRun: begin
        // A fetch fault takes priority over a data fault for the captured address.
        if (fetch_bad || data_bad) begin
          state_d      = StHalt;
          fault_d      = 1'b1;
          fault_addr_d = fetch_bad ? instr_addr : data_addr;
        end else if (should_write_mem) begin
          mem_we = 1'b1;
        end
      end
      StHalt: ;
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StLoad;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      fault_q      <= fault_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Reset does not clear the array; it only blocks a write that coincides with it.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[mem_waddr] <= mem_wdata;
  end

  assign fault      = fault_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_memory_responder.sv
// Randomized bench for memory_responder. It checks the design against a word-array model
// that applies the load, run and halt rules to plain arrays.
module tb_memory_responder;

  localparam int unsigned AW       = 10;
  localparam int unsigned Depth    = 2 ** AW;
  localparam logic [31:0] Base     = 32'h0000_0000;
  localparam logic [31:0] Nop      = 32'h0000_0013;
  localparam int          ModeLoad = 0;
  localparam int          ModeRun  = 1;
  localparam int          ModeHalt = 2;

  logic        clk, reset;
  logic [31:0] instr_addr, instr, data_addr, mem_write_data, mem_read_data;
  logic        should_read_mem, should_write_mem;
  logic        load_valid, load_ready, load_last;
  logic [31:0] load_addr, load_data;
  logic        core_hold, fault;
  logic [31:0] fault_addr;

  memory_responder #(.ADDR_WIDTH(AW), .BASE_ADDR(Base)) dut (
    .clk(clk), .reset(reset),
    .instr_addr(instr_addr), .instr(instr),
    .data_addr(data_addr), .should_read_mem(should_read_mem),
    .should_write_mem(should_write_mem), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .load_last(load_last),
    .core_hold(core_hold), .fault(fault), .fault_addr(fault_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          mdl_mode;
  logic        mdl_fault;
  logic [31:0] mdl_fault_addr;
  logic [31:0] mdl_mem [Depth];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ok(input logic [31:0] a);
    logic [31:0] off;
    off = a - Base;
    return (a >= Base) && ((off >> 2) < 32'(Depth)) && (a[1:0] == 2'b00);
  endfunction

  function automatic int idx(input logic [31:0] a);
    return int'((a - Base) >> 2);
  endfunction

  task automatic model_update();
    bit fb, db;
    if (reset) begin
      mdl_mode = ModeLoad; mdl_fault = 1'b0; mdl_fault_addr = '0;
    end else if (mdl_mode == ModeLoad) begin
      if (load_valid) begin
        if (!ok(load_addr)) begin
          mdl_fault = 1'b1; mdl_fault_addr = load_addr; mdl_mode = ModeHalt;
        end else begin
          mdl_mem[idx(load_addr)] = load_data;
          if (load_last) mdl_mode = ModeRun;
        end
      end
    end else if (mdl_mode == ModeRun) begin
      fb = !ok(instr_addr);
      db = ((should_read_mem || should_write_mem) && !ok(data_addr)) ||
           (should_read_mem && should_write_mem);
      if (fb || db) begin
        mdl_fault = 1'b1; mdl_fault_addr = fb ? instr_addr : data_addr; mdl_mode = ModeHalt;
      end else if (should_write_mem) begin
        mdl_mem[idx(data_addr)] = mem_write_data;
      end
    end
  endtask

  // Called at a negedge with the inputs already set. It returns at the next negedge.
  task automatic step();
    bit run;
    #1;
    run = (mdl_mode == ModeRun) && !reset;
    check("load_ready", load_ready, (mdl_mode == ModeLoad) && !reset);
    check("core_hold", core_hold, !run);
    if (!run) begin
      check("instr_nop", instr, Nop);
      check("rdata_zero", mem_read_data, 32'h0);
    end else begin
      if (ok(instr_addr)) check("instr", instr, mdl_mem[idx(instr_addr)]);
      if (!should_read_mem) check("rdata_idle", mem_read_data, 32'h0);
      else if (ok(data_addr)) check("rdata", mem_read_data, mdl_mem[idx(data_addr)]);
    end
    @(posedge clk);
    model_update();
    #1;
    check("fault", fault, mdl_fault);
    check("fault_addr", fault_addr, mdl_fault_addr);
    @(negedge clk);
  endtask

  task automatic idle();
    instr_addr = '0; data_addr = '0; should_read_mem = 0; should_write_mem = 0;
    mem_write_data = '0; load_valid = 0; load_addr = '0; load_data = '0; load_last = 0;
  endtask

  task automatic reload();
    idle(); reset = 1; step(); reset = 0;
    load_valid = 1; load_addr = 32'h0; load_data = 32'h0000_0093; load_last = 1; step();
    idle();
  endtask

  task automatic read_at(input logic [31:0] a);
    idle(); should_read_mem = 1; data_addr = a; step(); idle();
  endtask

  initial begin
    idle();
    reset = 1;
    mdl_mode = ModeLoad; mdl_fault = 0; mdl_fault_addr = '0;
    @(negedge clk);
    step(); step();
    reset = 0;

    // Full preload with random bubbles on load_valid.
    for (int i = 0; i < int'(Depth); i++) begin
      if ($urandom_range(0, 7) == 0) begin idle(); step(); end
      load_valid = 1;
      load_addr  = Base + 32'(i * 4);
      load_data  = (i == 0) ? 32'h0000_0093 : (i == 1) ? 32'h0010_0113 : $urandom;
      load_last  = (i == int'(Depth) - 1);
      step();
    end
    idle();

    instr_addr = 32'h4; step(); idle();
    should_write_mem = 1; data_addr = 32'h100; mem_write_data = 32'hDEAD_BEEF; step();
    read_at(32'h100);

    // Random legal traffic, kept clear of 0x100 so that word stays intact.
    for (int i = 0; i < 400; i++) begin
      int op;
      idle();
      op = int'($urandom_range(0, 2));
      instr_addr = Base + 32'($urandom_range(0, Depth - 1) * 4);
      data_addr  = Base + 32'($urandom_range(128, 143) * 4);
      mem_write_data = $urandom;
      should_read_mem  = (op == 1);
      should_write_mem = (op == 2);
      step();
    end
    idle(); step();

    // Misaligned load. After that the core stays halted and stores are ignored.
    should_read_mem = 1; data_addr = 32'h102; step(); idle();
    should_write_mem = 1; data_addr = 32'h8; mem_write_data = 32'h1234_5678; step(); idle();
    step();

    // A fetch fault beats a same-cycle store to 0x8.
    reload();
    instr_addr = 32'h1000; should_write_mem = 1; data_addr = 32'h8;
    mem_write_data = 32'hCAFE_F00D; step(); idle(); step();
    reload(); read_at(32'h8);

    // Read and write in the same cycle.
    should_read_mem = 1; should_write_mem = 1; data_addr = 32'h20;
    mem_write_data = 32'h0BAD_0BAD; step(); idle(); step();
    reload(); read_at(32'h20);

    // Reset arriving in RUN together with a store. The store is dropped and contents survive.
    should_write_mem = 1; data_addr = 32'h104; mem_write_data = 32'h55AA_55AA; reset = 1;
    step(); reset = 0; idle();
    load_valid = 1; load_addr = 32'h0; load_data = 32'h0000_0093; load_last = 1; step(); idle();
    read_at(32'h100); read_at(32'h104);

    // Loader faults: a misaligned address, then out-of-range addresses.
    reset = 1; step(); reset = 0;
    load_valid = 1; load_addr = 32'h6; load_data = 32'h1; step(); idle(); step();
    reset = 1; step(); reset = 0;
    load_valid = 1; load_addr = 32'h1000; load_data = 32'h2; load_last = 1; step(); idle(); step();
    reset = 1; step(); reset = 0;
    load_valid = 1; load_addr = 32'hFFFF_FFFC; load_data = 32'h3; step(); idle(); step();

    // Random fault injection after a few legal cycles.
    for (int t = 0; t < 12; t++) begin
      int kind;
      reload();
      for (int i = 0; i < 4; i++) begin
        idle();
        instr_addr = Base + 32'($urandom_range(0, Depth - 1) * 4);
        data_addr  = Base + 32'($urandom_range(128, 143) * 4);
        should_read_mem = $urandom_range(0, 1) == 1;
        step();
      end
      idle();
      kind = int'($urandom_range(0, 3));
      instr_addr = Base + 32'($urandom_range(0, Depth - 1) * 4);
      data_addr  = Base + 32'($urandom_range(128, 143) * 4);
      mem_write_data = $urandom;
      case (kind)
        0: instr_addr = instr_addr | 32'($urandom_range(1, 3));
        1: begin should_write_mem = 1; data_addr = Base + 32'(Depth * 4 + $urandom_range(0, 63) * 4); end
        2: begin should_read_mem = 1; should_write_mem = 1; end
        default: begin
          instr_addr = Base + 32'(Depth * 4);
          should_read_mem = 1; data_addr = 32'h3;
        end
      endcase
      step(); idle(); step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
